// File: rtl/stw_lap_control.sv
// stw_lap_control: stopwatch run/clear FSM with button synchronisers and a lap capture/recall buffer.
// Ports: i_clk, i_rst_n (async, active-low); i_sw_f1/f2/f3 start-stop, lap-clear, recall buttons;
// i_stw_time counter value; o_stw_on count enable; o_stw_rst_n counter clear; o_lap_cnt laps stored;
// o_lap_sel shown lap index; o_lap_time shown lap value; o_lap_view show lap; o_lap_ovf sticky lap drop.
module stw_lap_control #(
  parameter int TIME_W      = 24,
  parameter int LAP_DEPTH   = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(LAP_DEPTH + 1),
  localparam int SW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sw_f1,
  input  logic              i_sw_f2,
  input  logic              i_sw_f3,
  input  logic [TIME_W-1:0] i_stw_time,
  output logic              o_stw_on,
  output logic              o_stw_rst_n,
  output logic [CW-1:0]     o_lap_cnt,
  output logic [SW-1:0]     o_lap_sel,
  output logic [TIME_W-1:0] o_lap_time,
  output logic              o_lap_view,
  output logic              o_lap_ovf
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t            r_state, w_state;
  logic [2:0]        r_sync [SYNC_STAGES];
  logic [2:0]        r_prev;
  logic [2:0]        w_rise;
  logic              w_e1, w_e2, w_e3, w_recall, w_wr;
  logic [CW-1:0]     r_lap_cnt, w_cnt;
  logic [SW-1:0]     r_lap_sel, w_sel;
  logic              r_lap_view, w_view, r_lap_ovf, w_ovf;
  logic [TIME_W-1:0] r_lap_mem [LAP_DEPTH];
  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  // same-cycle edges resolve F1 > F2 > F3; losers are dropped
  assign w_e1 = w_rise[0];
  assign w_e2 = w_rise[1] & ~w_rise[0];
  assign w_e3 = w_rise[2] & ~w_rise[1] & ~w_rise[0];
  assign w_recall = w_e3 && r_state != RUN && r_lap_cnt != '0;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_lap_cnt;
    w_sel   = r_lap_sel;
    w_view  = r_lap_view;
    w_ovf   = r_lap_ovf;
    w_wr    = 1'b0;
    if (w_e1 || w_e2) begin
      w_view = 1'b0;
      w_sel  = '0;
    end
    case (r_state)
      IDLE: if (w_e1) begin
        w_state = RUN;
        w_cnt   = '0;
        w_ovf   = 1'b0;
      end
      RUN: if (w_e1) w_state = PAUSE;
        else if (w_e2) begin
          if (r_lap_cnt == CW'(LAP_DEPTH)) w_ovf = 1'b1;
          else begin
            w_wr  = 1'b1;
            w_cnt = r_lap_cnt + CW'(1);
          end
        end
      PAUSE: if (w_e1) w_state = RUN;
        else if (w_e2) begin
          w_state = IDLE;
          w_cnt   = '0;
          w_ovf   = 1'b0;
        end
      default: w_state = IDLE;
    endcase
    if (w_recall) begin
      w_view = 1'b1;
      w_sel  = !r_lap_view ? '0 : (CW'(r_lap_sel) == r_lap_cnt - CW'(1)) ? '0 : r_lap_sel + SW'(1);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev     <= '0;
      r_state    <= IDLE;
      r_lap_cnt  <= '0;
      r_lap_sel  <= '0;
      r_lap_view <= 1'b0;
      r_lap_ovf  <= 1'b0;
    end else begin
      r_sync[0] <= {i_sw_f3, i_sw_f2, i_sw_f1};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev     <= r_sync[SYNC_STAGES-1];
      r_state    <= w_state;
      r_lap_cnt  <= w_cnt;
      r_lap_sel  <= w_sel;
      r_lap_view <= w_view;
      r_lap_ovf  <= w_ovf;
    end
  end
  // lap storage needs no reset: reads are masked until a lap is written
  always_ff @(posedge i_clk) begin
    if (w_wr) r_lap_mem[SW'(r_lap_cnt)] <= i_stw_time;
  end
  assign o_stw_on    = r_state == RUN;
  assign o_stw_rst_n = r_state != IDLE;
  assign o_lap_cnt   = r_lap_cnt;
  assign o_lap_sel   = r_lap_sel;
  assign o_lap_view  = r_lap_view;
  assign o_lap_ovf   = r_lap_ovf;
  assign o_lap_time  = (r_lap_cnt == '0) ? '0 : r_lap_mem[r_lap_sel];
endmodule

// File: tb/tb_stw_lap_control.sv
// tb_stw_lap_control: directed table-driven check of stw_lap_control run/lap/recall/clear behaviour.
module tb_stw_lap_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  logic [23:0] stw_time = '0;
  logic        stw_on, stw_rst_n, lap_view, lap_ovf;
  logic [3:0]  lap_cnt;
  logic [2:0]  lap_sel;
  logic [23:0] lap_time;
  int          n_vec = 0;
  int          n_err = 0;
  typedef struct {
    logic        f1, f2, f3;
    logic [23:0] t;
    logic [34:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [23:0] laps [8];
  always #5 clk = ~clk;
  stw_lap_control dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_f1(f1), .i_sw_f2(f2), .i_sw_f3(f3),
    .i_stw_time(stw_time), .o_stw_on(stw_on), .o_stw_rst_n(stw_rst_n), .o_lap_cnt(lap_cnt),
    .o_lap_sel(lap_sel), .o_lap_time(lap_time), .o_lap_view(lap_view), .o_lap_ovf(lap_ovf)
  );
  function automatic logic [34:0] e(bit on, bit rn, int cnt, int sel, bit view, bit ovf, logic [23:0] lt);
    return {on, rn, 4'(cnt), 3'(sel), view, ovf, lt};
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string nm, logic [34:0] exp);
    logic [34:0] act;
    act = {stw_on, stw_rst_n, lap_cnt, lap_sel, lap_view, lap_ovf, lap_time};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got on/rn/cnt/sel/view/ovf/time=%h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(bit a, bit b, bit c, logic [23:0] t, logic [34:0] exp);
    vec_t v;
    v.f1 = a; v.f2 = b; v.f3 = c; v.t = t; v.exp = exp;
    tbl.push_back(v);
  endtask
  task automatic press(bit a, bit b, bit c, logic [23:0] t, logic [34:0] exp, string nm);
    stw_time = t;
    {f1, f2, f3} = {a, b, c};
    tick();
    {f1, f2, f3} = 3'b000;
    tick(4);
    chk(nm, exp);
  endtask
  initial begin
    laps = '{24'h000123, 24'h000456, 24'h000789, 24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004, 24'hA00005};
    add(0, 1, 0, 24'h000123, e(1, 1, 1, 0, 0, 0, 24'h123));
    add(0, 1, 0, 24'h000456, e(1, 1, 2, 0, 0, 0, 24'h123));
    add(0, 1, 0, 24'h000789, e(1, 1, 3, 0, 0, 0, 24'h123));
    add(0, 0, 1, 24'h0,      e(1, 1, 3, 0, 0, 0, 24'h123));
    add(1, 0, 0, 24'h0,      e(0, 1, 3, 0, 0, 0, 24'h123));
    add(0, 0, 1, 24'h0,      e(0, 1, 3, 0, 1, 0, 24'h123));
    add(0, 0, 1, 24'h0,      e(0, 1, 3, 1, 1, 0, 24'h456));
    add(0, 0, 1, 24'h0,      e(0, 1, 3, 2, 1, 0, 24'h789));
    add(0, 0, 1, 24'h0,      e(0, 1, 3, 0, 1, 0, 24'h123));
    add(1, 1, 0, 24'h0,      e(1, 1, 3, 0, 0, 0, 24'h123));
    for (int i = 3; i < 8; i++) add(0, 1, 0, laps[i], e(1, 1, i + 1, 0, 0, 0, 24'h123));
    add(0, 1, 0, 24'hA00006, e(1, 1, 8, 0, 0, 1, 24'h123));
    add(1, 0, 0, 24'h0,      e(0, 1, 8, 0, 0, 1, 24'h123));
    for (int i = 0; i < 8; i++) add(0, 0, 1, 24'h0, e(0, 1, 8, i, 1, 1, laps[i]));
    add(0, 0, 1, 24'h0,      e(0, 1, 8, 0, 1, 1, 24'h123));
    add(0, 1, 0, 24'h0,      e(0, 0, 0, 0, 0, 0, 24'h0));
    add(0, 0, 1, 24'h0,      e(0, 0, 0, 0, 0, 0, 24'h0));
    add(1, 0, 0, 24'h0,      e(1, 1, 0, 0, 0, 0, 24'h0));
    add(0, 1, 0, 24'h5A5A5A, e(1, 1, 1, 0, 0, 0, 24'h5A5A5A));
    #12;
    chk("reset", e(0, 0, 0, 0, 0, 0, 24'h0));
    rst_n = 1'b1;
    tick(3);
    chk("idle_after_reset", e(0, 0, 0, 0, 0, 0, 24'h0));
    f1 = 1'b1;
    tick();
    chk("start_edge_k", e(0, 0, 0, 0, 0, 0, 24'h0));
    tick();
    chk("start_edge_k1", e(0, 0, 0, 0, 0, 0, 24'h0));
    tick();
    chk("start_edge_k2", e(1, 1, 0, 0, 0, 0, 24'h0));
    tick(2);
    f1 = 1'b0;
    tick(4);
    for (int i = 0; i < tbl.size(); i++)
      press(tbl[i].f1, tbl[i].f2, tbl[i].f3, tbl[i].t, tbl[i].exp, $sformatf("vec%0d", i));
    stw_time = 24'h111111;
    f2 = 1'b1;
    tick(50);
    f2 = 1'b0;
    tick(4);
    chk("held_f2_one_lap", e(1, 1, 2, 0, 0, 0, 24'h5A5A5A));
    press(0, 0, 1, 24'h0, e(1, 1, 2, 0, 0, 0, 24'h5A5A5A), "f3_in_run");
    press(1, 0, 0, 24'h0, e(0, 1, 2, 0, 0, 0, 24'h5A5A5A), "pause2");
    press(0, 0, 1, 24'h0, e(0, 1, 2, 0, 1, 0, 24'h5A5A5A), "recall2_0");
    press(0, 0, 1, 24'h0, e(0, 1, 2, 1, 1, 0, 24'h111111), "recall2_1");
    press(1, 0, 0, 24'h0, e(1, 1, 2, 0, 0, 0, 24'h5A5A5A), "run_clears_view");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", e(0, 0, 0, 0, 0, 0, 24'h0));
    #3 rst_n = 1'b1;
    tick(3);
    chk("after_release", e(0, 0, 0, 0, 0, 0, 24'h0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
